// File: rtl/fmul_pipe.sv
// fmul_pipe: four-stage pipelined floating-point multiplier with valid/ready backpressure.
// Optional macro FMUL_RNE_EN selects round-to-nearest-even; the default build truncates.
module fmul_pipe #(
   parameter int EXP_W = 7,
   parameter int MAN_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     float_a,
   input  logic [EXP_W+MAN_W:0]     float_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     float_out,
   output logic                     float_out_overflow,
   output logic                     float_out_underflow
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int P_W = 2 * MAN_W + 2;
   localparam int E_W = EXP_W + 2;
   localparam logic signed [E_W-1:0] BIAS    = E_W'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [E_W-1:0] EXP_MAX = E_W'(2 ** EXP_W - 1);
   localparam logic signed [E_W-1:0] EXP_MIN = E_W'(1);

   // Returns {overflow, underflow, word}; zero operands win over any range violation.
   function automatic logic [W+1:0] pack_result(
      input logic                  s,
      input logic signed [E_W-1:0] e,
      input logic [MAN_W-1:0]      f,
      input logic                  z
   );
      if (z)
         return {2'b00, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      else if (e > EXP_MAX)
         return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      else if (e < EXP_MIN)
         return {2'b01, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      else
         return {2'b00, s, e[EXP_W-1:0], f};
   endfunction

`ifdef FMUL_RNE_EN
   // Result bit MAN_W is the carry out of the fraction (1.11..1 rounded up to 10.00..0).
   function automatic logic [MAN_W:0] round_rne(
      input logic [MAN_W-1:0] f,
      input logic             g,
      input logic             s
   );
      logic up;
      up = g & (s | f[0]);
      return {1'b0, f} + (MAN_W + 1)'(up);
   endfunction
`endif

   logic advance;
   logic vld_p1, vld_p2, vld_p3;

   logic [W-1:0]            a_p1, b_p1;
   logic                    sign_p2, zero_p2;
   logic signed [E_W-1:0]   exp_p2;
   logic [P_W-1:0]          prod_p2;
   logic [W-1:0]            res_p3;
   logic                    ovf_p3, udf_p3;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---- S1 -> S2: sign, biased exponent sum, full significand product
   logic [EXP_W-1:0] ea, eb;
   logic [P_W-1:0]   sig_a, sig_b;

   assign ea    = a_p1[W-2:MAN_W];
   assign eb    = b_p1[W-2:MAN_W];
   assign sig_a = P_W'({1'b1, a_p1[MAN_W-1:0]});
   assign sig_b = P_W'({1'b1, b_p1[MAN_W-1:0]});

   // ---- S2 -> S3: normalise, round, range check
   logic                  msb;
   logic signed [E_W-1:0] exp_norm, exp_n;
   logic [MAN_W-1:0]      frac_t, frac_n;
   logic [W+1:0]          packed_n;

   assign msb      = prod_p2[P_W-1];
   assign exp_norm = exp_p2 + $signed({{(E_W-1){1'b0}}, msb});
   assign frac_t   = msb ? prod_p2[P_W-2 -: MAN_W] : prod_p2[P_W-3 -: MAN_W];

`ifdef FMUL_RNE_EN
   logic             guard, sticky;
   logic [MAN_W:0]   rounded;

   assign guard   = msb ? prod_p2[MAN_W]        : prod_p2[MAN_W-1];
   assign sticky  = msb ? |prod_p2[MAN_W-1:0]   : |prod_p2[MAN_W-2:0];
   assign rounded = round_rne(frac_t, guard, sticky);
   assign frac_n  = rounded[MAN_W-1:0];
   assign exp_n   = exp_norm + $signed({{(E_W-1){1'b0}}, rounded[MAN_W]});
`else
   logic unused_lsbs;

   assign unused_lsbs = ^prod_p2[MAN_W-1:0];
   assign frac_n      = frac_t;
   assign exp_n       = exp_norm;
`endif

   assign packed_n = pack_result(sign_p2, exp_n, frac_n, zero_p2);

   // Control path and output register: reset clears valids and the visible result.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1              <= 1'b0;
         vld_p2              <= 1'b0;
         vld_p3              <= 1'b0;
         out_valid           <= 1'b0;
         float_out           <= '0;
         float_out_overflow  <= 1'b0;
         float_out_underflow <= 1'b0;
      end else if (advance) begin
         vld_p1              <= in_valid;
         vld_p2              <= vld_p1;
         vld_p3              <= vld_p2;
         out_valid           <= vld_p3;
         float_out           <= res_p3;
         float_out_overflow  <= ovf_p3;
         float_out_underflow <= udf_p3;
      end
   end

   // Internal datapath registers: contents are meaningless unless the matching vld_pN is set.
   always_ff @(posedge clk) begin
      if (advance) begin
         a_p1    <= float_a;
         b_p1    <= float_b;
         sign_p2 <= a_p1[W-1] ^ b_p1[W-1];
         zero_p2 <= (ea == '0) || (eb == '0);
         exp_p2  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
         prod_p2 <= sig_a * sig_b;
         res_p3  <= packed_n[W-1:0];
         ovf_p3  <= packed_n[W+1];
         udf_p3  <= packed_n[W];
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vectors with a queue scoreboard for fmul_pipe at default parameters.
// Rounding expectations follow FMUL_RNE_EN when it is defined for the bench build.
module tb_fmul_pipe;

   localparam int W = 24;

   typedef struct {
      logic [W-1:0] word;
      logic         ov;
      logic         ud;
      int           acc;
      logic         lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  float_a = '0;
   logic [W-1:0]  float_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  float_out;
   logic          ovf, udf;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   fmul_pipe dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .float_a             (float_a),
      .float_b             (float_b),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .float_out           (float_out),
      .float_out_overflow  (ovf),
      .float_out_underflow (udf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Issue one operand pair; the expected result is queued when acceptance is certain.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic ov, input logic ud, input logic lat);
      exp_t t;
      int   g;
      in_valid = 1'b1;
      float_a  = a;
      float_b  = b;
      g        = 0;
      @(negedge clk);
      while (!in_ready && g < 50) begin
         g++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stuck at 0 for operands %h x %h", a, b);
         in_valid = 1'b0;
      end else begin
         t.word = e;
         t.ov   = ov;
         t.ud   = ud;
         t.acc  = cyc;
         t.lat  = lat;
         q.push_back(t);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() != 0 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: every presented result is compared with the queue head, including while stalled.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, required no result", float_out);
         end else begin
            check("result", {ovf, udf, float_out}, {q[0].ov, q[0].ud, q[0].word});
            if (out_ready) begin
               if (q[0].lat)
                  check("latency", (W+2)'(cyc - q[0].acc), (W+2)'(4));
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] rnd_exp;
      logic [W-1:0] bp_b [8];
      int           g;
`ifdef FMUL_RNE_EN
      rnd_exp = 24'h3F8002;
`else
      rnd_exp = 24'h3F8001;
`endif
      bp_b = '{24'h3F1234, 24'h401111, 24'hC02222, 24'h423333,
               24'h3D4444, 24'hBE5555, 24'h416666, 24'h3F7777};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out", {ovf, udf, float_out}, '0);
      check("reset_valid", (W+2)'(out_valid), '0);
      check("reset_ready", (W+2)'(in_ready), (W+2)'(1));
      out_ready = 1'b1;

      send(24'h3F0000, 24'h3F0000, 24'h3F0000, 1'b0, 1'b0, 1'b1);
      drain();
      send(24'h3F8000, 24'h3F8000, 24'h402000, 1'b0, 1'b0, 1'b1);
      drain();

      send(24'hC00000, 24'h3F8000, 24'hC08000, 1'b0, 1'b0, 1'b1);
      send(24'h000123, 24'h3F8000, 24'h000000, 1'b0, 1'b0, 1'b1);
      send(24'h7F0000, 24'h7F0000, 24'h7FFFFF, 1'b1, 1'b0, 1'b1);
      send(24'h810000, 24'h010000, 24'h800000, 1'b0, 1'b1, 1'b1);
      send(24'h3F0001, 24'h3F8000, rnd_exp,    1'b0, 1'b0, 1'b1);
      send(24'h400000, 24'h400000, 24'h410000, 1'b0, 1'b0, 1'b1);
      drain();

      // Backpressure: eight back-to-back pairs, consumer stalls 3 cycles after the first result.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(24'h3F0000, bp_b[i], bp_b[i], 1'b0, 1'b0, 1'b0);
         end
         begin
            g = 0;
            while (!out_valid && g < 50) begin
               @(posedge clk);
               #1;
               g++;
            end
            if (!out_valid) begin
               n_vec++;
               n_bad++;
               $display("FAIL bp_first_result: out_valid never rose, required 1");
            end else begin
               @(posedge clk);
               #1;
               out_ready = 1'b0;
               #1;
               check("bp_in_ready", (W+2)'(in_ready), '0);
               repeat (3) @(posedge clk);
               #1;
               out_ready = 1'b1;
            end
         end
      join
      drain();

      // Reset with three items in flight: none of them may ever appear.
      send(24'h3F0000, 24'h3F1111, 24'h3F1111, 1'b0, 1'b0, 1'b0);
      send(24'h3F0000, 24'h3F2222, 24'h3F2222, 1'b0, 1'b0, 1'b0);
      send(24'h3F0000, 24'h3F3333, 24'h3F3333, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_valid", (W+2)'(out_valid), '0);
      check("rst_mid_ready", (W+2)'(in_ready), (W+2)'(1));
      repeat (6) @(posedge clk);
      #1;
      send(24'h3F8000, 24'hC00000, 24'hC08000, 1'b0, 1'b0, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
